mc_main_fsm: RTL
================

# mc_main_fsm

Multicycle ARM main controller FSM that generates the write enables and datapath selects for the processor's enabled registers (PC, IR, register file write port, data memory write). It decodes the instruction fields held in the IR and steps one instruction through Fetch → Decode → Execute → Writeback states. A memory handshake stretches memory-access states. It sits between the instruction register and the datapath muxes and enable inputs.

## Interface
Parameters:
- none

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising clk edge
- op  input  2  instruction bits [27:26]: 00 data-proc, 01 memory, 10 branch, 11 undefined
- funct  input  6  instruction bits [25:20]; funct[5] = I (immediate), funct[0] = L (load)
- condex  input  1  condition-check result for the current instruction, from external flag logic
- mem_ready  input  1  memory completes the current access this cycle
- pcwrite  output  1  PC register enable
- irwrite  output  1  IR register enable
- regwrite  output  1  register file write enable
- memwrite  output  1  data memory write strobe
- adrsrc  output  1  address mux: 0 = PC, 1 = ALU result register
- alusrca  output  1  ALU A: 0 = register A, 1 = PC
- alusrcb  output  2  ALU B: 00 register B, 01 extended immediate, 10 constant 4
- resultsrc  output  2  result mux: 00 ALUOut, 01 Data, 10 ALU direct
- aluop  output  1  1 = ALU decoder uses funct, 0 = force ADD
- state  output  4  current state encoding (debug/verification)

## Operation
- Moore FSM; all outputs are combinational decodes of the state register and of mem_ready/condex (enables only). Unlisted outputs are 0.
- State encodings and outputs:
  - FETCH=0: adrsrc=0, alusrca=1, alusrcb=10, aluop=0, resultsrc=10; irwrite=mem_ready; nextpc=mem_ready.
  - DECODE=1: alusrca=1, alusrcb=10, aluop=0, resultsrc=10.
  - MEMADR=2: alusrca=0, alusrcb=01, aluop=0.
  - MEMREAD=3: adrsrc=1, resultsrc=00.
  - MEMWB=4: resultsrc=01, regw=1.
  - MEMWRITE=5: adrsrc=1, resultsrc=00, memw=mem_ready.
  - EXECUTER=6: alusrca=0, alusrcb=00, aluop=1.
  - EXECUTEI=7: alusrca=0, alusrcb=01, aluop=1.
  - ALUWB=8: resultsrc=00, regw=1.
  - BRANCH=9: alusrca=0, alusrcb=01, aluop=0, resultsrc=10, branch=1.
- Gated enables: pcwrite = nextpc | (branch & condex); regwrite = regw & condex; memwrite = memw & condex.
- Transitions:
  - FETCH → DECODE if mem_ready, else stay.
  - DECODE → MEMADR (op=01); EXECUTER (op=00, funct[5]=0); EXECUTEI (op=00, funct[5]=1); BRANCH (op=10); FETCH (op=11, no writes).
  - MEMADR → MEMREAD (funct[0]=1) else MEMWRITE.
  - MEMREAD → MEMWB if mem_ready, else stay. MEMWB → FETCH.
  - MEMWRITE → FETCH if mem_ready, else stay.
  - EXECUTER, EXECUTEI → ALUWB → FETCH. BRANCH → FETCH.
  - Encodings 10–15 (unreachable) → FETCH, all outputs 0.
- condex=0 suppresses regwrite, memwrite and the branch contribution to pcwrite. The FSM path is unchanged.

## Timing
- reset high at a rising edge: state=FETCH on the next cycle, overriding any transition. Mid-instruction reset aborts the instruction, and no writes follow.
- While reset is held, state stays FETCH. Enables are not forced low by reset: irwrite/pcwrite follow mem_ready in FETCH. Integration holds mem_ready=0 during reset.
- Cycles per instruction with mem_ready always 1:
  - load 5 (F, D, MA, MR, WB)
  - store 4
  - data-proc 4
  - branch 3
  - undefined 2
- Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds exactly one cycle. Enables in those states assert only in the cycle where mem_ready=1, exactly once per access.
- condex is sampled combinationally in the enable cycle (ALUWB, MEMWB, MEMWRITE, BRANCH).

## Test plan
- Reset: assert reset 2 cycles with FSM in EXECUTER → state=0 the cycle after the first edge; after release with mem_ready=1, irwrite=pcwrite=1 for one cycle, then state=1.
- LDR: op=01, funct=011001, condex=1, mem_ready=1 → states 0,1,2,3,4,0. regwrite=1 only in state 4 with resultsrc=01. adrsrc=1 in state 3.
- STR with wait: op=01, funct=011000, mem_ready low 2 cycles in MEMWRITE → state 5 held 3 cycles. memwrite=1 only in the third cycle, then state 0.
- ADD reg/imm: op=00, funct[5]=0 → 0,1,6,8,0 with aluop=1, alusrcb=00 in 6. funct[5]=1 → state 7 with alusrcb=01. regwrite=1 in state 8.
- Branch taken/not taken: op=10, condex=1 → pcwrite=1 in state 9. With condex=0 → pcwrite=0 in 9. Both return to 0 next cycle.
- Condition fail and undefined: data-proc with condex=0 → regwrite=0 in ALUWB. op=11 → 0,1,0 with no writes.

Source files
------------

// File: rtl/mc_main_fsm.sv
// Multicycle ARM main controller: steps one instruction through fetch/decode/execute/writeback
// and drives the register enables and datapath selects as Moore decodes of the state.
module mc_main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       condex,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       adrsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       aluop,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   nextpc, branch, regw, memw;

  // Only the I and L bits of funct steer the controller.
  logic unused_funct;
  assign unused_funct = ^funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    nextpc    = 1'b0;
    branch    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    irwrite   = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    aluop     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        nextpc    = mem_ready;
      end
      S_DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_MEMADR:   alusrcb = 2'b01;
      S_MEMREAD:  adrsrc  = 1'b1;
      S_MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        memw   = mem_ready;
      end
      S_EXECUTER: aluop = 1'b1;
      S_EXECUTEI: begin
        alusrcb = 2'b01;
        aluop   = 1'b1;
      end
      S_ALUWB:    regw = 1'b1;
      S_BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // A failed condition kills architectural writes without altering the state sequence.
  assign pcwrite  = nextpc | (branch & condex);
  assign regwrite = regw & condex;
  assign memwrite = memw & condex;
  assign state    = state_q;

endmodule
